// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: command bytes, device replies, FSM encoding.
package ps2_host_tx_pkg;
  localparam logic [7:0] CMD_LED    = 8'hED;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RATE   = 8'hF3;
  localparam logic [7:0] DEV_ACK    = 8'hFA;
  localparam logic [7:0] DEV_RESEND = 8'hFE;
  localparam logic [7:0] DEV_BAT_OK = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_REL
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// Command request plus open-drain PS/2 pin bundle between the host transmitter and its user.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       ps2clk, ps2dat, ps2clk_oe, ps2dat_oe;
  logic       busy, rx_inhibit, done, ack_err, timeout_err;

  modport master (
    output tx_data, tx_valid, ps2clk, ps2dat,
    input  tx_ready, ps2clk_oe, ps2dat_oe, busy, rx_inhibit, done, ack_err, timeout_err
  );
  modport slave (
    input  tx_data, tx_valid, ps2clk, ps2dat,
    output tx_ready, ps2clk_oe, ps2dat_oe, busy, rx_inhibit, done, ack_err, timeout_err
  );
endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 line plus falling-edge strobe on the synced value.
module ps2_host_tx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_fall
);
  logic [1:0] r_meta;
  logic       r_prev;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false fall.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_meta <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_meta <= {r_meta[0], i_pin};
      r_prev <= r_meta[1];
    end

  assign o_sync = r_meta[1];
  assign o_fall = r_prev & ~r_meta[1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked-out bits, ack check.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int START_TIMEOUT  = 375000,
  parameter int BIT_TIMEOUT    = 50000
) (
  input logic         clk,
  input logic         reset,
  ps2_host_tx_if.slave bus
);
  localparam int MAX_A   = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic w_clk_sync, w_clk_fall, w_adv;
  logic [1:0] r_dat_meta;

  ps2_host_tx_sync_edge u_clk_sync (
    .clk    (clk),
    .reset  (reset),
    .i_pin  (bus.ps2clk),
    .o_sync (w_clk_sync),
    .o_fall (w_clk_fall)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) r_dat_meta <= 2'b11;
    else       r_dat_meta <= {r_dat_meta[0], bus.ps2dat};

  state_t          r_state;
  logic [8:0]      r_sh;
  logic [3:0]      r_nfall;
  logic [CW-1:0]   r_cnt;
  logic            r_ready, r_clk_oe, r_dat_oe, r_done, r_ack_err, r_to_err;

  // Event that moves a device-clocked state forward; its absence runs the timeout.
  always_comb begin
    w_adv = 1'b0;
    case (r_state)
      S_SHIFT, S_ACK: w_adv = w_clk_fall;
      S_WAIT_REL:     w_adv = w_clk_sync & r_dat_meta[1];
      default:        w_adv = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= S_IDLE;
      r_sh      <= '0;
      r_nfall   <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (bus.tx_valid && r_ready) begin
            r_sh      <= {odd_parity(bus.tx_data), bus.tx_data};
            r_ack_err <= 1'b0;
            r_to_err  <= 1'b0;
            r_ready   <= 1'b0;
            r_clk_oe  <= 1'b1;
            r_cnt     <= CW'(INHIBIT_CYCLES - 1);
            r_state   <= S_INHIBIT;
          end
        end
        S_INHIBIT:
          if (r_cnt == '0) begin
            r_dat_oe <= 1'b1;
            r_state  <= S_REQ;
          end else r_cnt <= r_cnt - 1'b1;
        S_REQ: begin
          r_clk_oe <= 1'b0;
          r_nfall  <= '0;
          r_cnt    <= CW'(START_TIMEOUT);
          r_state  <= S_SHIFT;
        end
        S_SHIFT, S_ACK, S_WAIT_REL:
          if (!w_adv) begin
            if (r_cnt == '0) begin
              r_clk_oe <= 1'b0;
              r_dat_oe <= 1'b0;
              r_done   <= 1'b1;
              r_to_err <= 1'b1;
              r_ready  <= 1'b1;
              r_state  <= S_IDLE;
            end else r_cnt <= r_cnt - 1'b1;
          end else begin
            r_cnt <= CW'(BIT_TIMEOUT);
            case (r_state)
              S_SHIFT: begin
                // Shifting in ones makes the 10th fall present the stop bit (line released).
                r_dat_oe <= ~r_sh[0];
                r_sh     <= {1'b1, r_sh[8:1]};
                r_nfall  <= r_nfall + 4'd1;
                if (r_nfall == 4'd9) r_state <= S_ACK;
              end
              S_ACK: begin
                r_ack_err <= r_dat_meta[1];
                r_state   <= S_WAIT_REL;
              end
              default: begin
                r_done  <= 1'b1;
                r_ready <= 1'b1;
                r_state <= S_IDLE;
              end
            endcase
          end
        default: r_state <= S_IDLE;
      endcase
    end

  assign bus.tx_ready    = r_ready;
  assign bus.ps2clk_oe   = r_clk_oe;
  assign bus.ps2dat_oe   = r_dat_oe;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.rx_inhibit  = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.ack_err     = r_ack_err;
  assign bus.timeout_err = r_to_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx: device BFM on open-drain lines plus frame-level reference model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH = 20;
  localparam int ST  = 600;
  localparam int BT  = 200;
  localparam int H   = 20;   // device half clock period in system cycles

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();
  logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  assign bus.ps2clk = ~(bus.ps2clk_oe | dev_clk_low);
  assign bus.ps2dat = ~(bus.ps2dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .BIT_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0, bad = 0;
  int exp_dones = 0, dones_seen = 0, rst_age = 0;
  logic exp_ack = 1'b0, exp_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Per-cycle compare against the frame-level model.
  initial forever begin
    @(negedge clk);
    if (reset) rst_age = 0;
    else begin
      if (rst_age < 5) rst_age++;
      check("inhibit_eq_busy", 32'(bus.rx_inhibit), 32'(bus.busy));
      if (rst_age >= 3) check("ready_idle", 32'(bus.tx_ready), 32'(!bus.busy));
      if (!bus.busy) check("idle_lines", {bus.ps2clk_oe, bus.ps2dat_oe}, 0);
      if (bus.done) begin
        dones_seen++;
        check("done_count", dones_seen, exp_dones);
        check("ack_err", 32'(bus.ack_err), 32'(exp_ack));
        check("timeout_err", 32'(bus.timeout_err), 32'(exp_to));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic device(input int nfalls, input bit ack, output logic [9:0] bits);
    bits = '0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < nfalls; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      @(negedge clk);
      bits[k] = bus.ps2dat;
      repeat (H - 1) @(negedge clk);
    end
    if (nfalls == 10) begin
      if (ack) dev_dat_low = 1'b1;
      repeat (H / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (H / 2) @(negedge clk);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_seen", 0, 1);
  endtask

  task automatic start(input logic [7:0] d, input int mode, input bit drive, input bit hold,
                       input logic [7:0] nxt, output bit ok);
    int n, inh;
    ok = 1'b0;
    #1;
    check("flags_hold", {bus.ack_err, bus.timeout_err}, {exp_ack, exp_to});
    exp_ack = (mode == 1);
    exp_to  = (mode == 2);
    exp_dones++;
    if (drive) begin
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
    end
    n = 0;
    while (!(bus.tx_valid && bus.tx_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("accept_seen", 0, 1);
      return;
    end
    @(posedge clk);
    #1;
    if (hold) bus.tx_data = nxt;
    else begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
    end
    inh = 0;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.ps2dat_oe || n > 200) break;
      if (bus.ps2clk_oe) inh++;
    end
    check("inhibit_len", inh, INH);
    check("req_clk_low", 32'(bus.ps2clk_oe), 1);
    @(negedge clk);
    check("release", {bus.ps2clk_oe, bus.ps2dat_oe}, 2'b01);
    ok = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input int mode, input bit drive, input bit hold,
                       input logic [7:0] nxt, output logic [9:0] bits);
    bit ok;
    int n;
    bits = '0;
    start(d, mode, drive, hold, nxt, ok);
    if (!ok) return;
    fork
      begin if (mode != 2) device(10, mode == 0, bits); end
      begin wait_done(n); end
    join
    if (mode == 2) check("timeout_latency", 32'(n >= ST && n <= ST + 2), 1);
    else check("bfm_frame", bits, {1'b1, par(d), d});
  endtask

  logic [9:0] bits;
  bit ok;

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_oe", {bus.ps2clk_oe, bus.ps2dat_oe}, 0);
    check("rst_flags", {bus.done, bus.busy, bus.ack_err, bus.timeout_err}, 0);
    check("rst_ready", 32'(bus.tx_ready), 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.tx_ready), 1);

    frame(CMD_LED, 0, 1'b1, 1'b0, 8'h00, bits);
    check("ed_literal", bits, 10'b11_1110_1101);
    frame(8'h00, 0, 1'b1, 1'b0, 8'h00, bits);
    check("par_00", 32'(bits[8]), 1);
    frame(8'hFF, 0, 1'b1, 1'b0, 8'h00, bits);
    check("par_ff", 32'(bits[8]), 1);
    frame(8'h01, 0, 1'b1, 1'b0, 8'h00, bits);
    check("par_01", 32'(bits[8]), 0);
    frame(CMD_RATE, 1, 1'b1, 1'b0, 8'h00, bits);
    frame(CMD_RESET, 2, 1'b1, 1'b0, 8'h00, bits);

    // Reset after the fourth device fall of an enable command.
    start(CMD_ENABLE, 0, 1'b1, 1'b0, 8'h00, ok);
    if (ok) begin
      device(4, 1'b0, bits);
      check("abort_bits", 32'(bits[3:0]), 4'h4);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort_oe", {bus.ps2clk_oe, bus.ps2dat_oe}, 0);
      check("abort_done", {bus.done, bus.busy}, 0);
      exp_dones--;
      exp_ack = 1'b0;
      exp_to  = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
    end
    frame(CMD_RESET, 0, 1'b1, 1'b0, 8'h00, bits);
    check("ff_after_abort", bits, 10'b11_1111_1111);

    // tx_valid stays high with the next byte while the first is in flight.
    @(negedge clk);
    bus.tx_data  = CMD_LED;
    bus.tx_valid = 1'b1;
    frame(CMD_LED, 0, 1'b0, 1'b1, 8'h02, bits);
    frame(8'h02, 0, 1'b0, 1'b0, 8'h00, bits);
    check("b2b_second", bits, 10'b10_0000_0010);

    for (int i = 0; i < 12; i++) begin
      int r;
      r = $urandom_range(0, 9);
      frame(8'($urandom), (r < 7) ? 0 : (r < 9) ? 1 : 2, 1'b1, 1'b0, 8'h00, bits);
    end

    repeat (20) @(negedge clk);
    check("done_total", dones_seen, exp_dones);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
